case_sel_counter: RTL
=====================

Name: case_sel_counter

Overview:
- Sequential successor to the combinational "case on post-incremented selector" construct.
- Holds a WIDTH-bit selector counter and a table of NCASE programmable case items.
- On each valid request, the pre-increment counter value is matched against the case items in priority order, then the counter increments. The increment point is explicit and cycle-exact.
- Sits behind the SV frontend regression harness as a reference model for case/increment ordering semantics.

Parameters:
- WIDTH, 4, selector/counter and case-item width in bits.
- NCASE, 2, number of case items; must be ≥1.
- OUTW, 32, width of the result code.
- IDXW, $clog2(NCASE) (minimum 1), width of item index fields.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_vld  in  1  load counter with load_val.
- load_val  in  WIDTH  counter load value.
- cfg_we  in  1  write one case-item entry.
- cfg_idx  in  IDXW  entry index.
- cfg_val  in  WIDTH  case-item match value.
- cfg_code  in  OUTW  code returned on match.
- cfg_en  in  1  entry enable written with the entry.
- req_vld  in  1  evaluate case on the current counter value, then increment.
- cnt  out  WIDTH  current counter value.
- res_vld  out  1  result valid (one-cycle pulse per request).
- res_hit  out  1  some enabled entry matched.
- res_idx  out  IDXW  index of the winning entry.
- res_code  out  OUTW  result code.

Behaviour:
- Reset (rst_n=0, async assert, sync deassert at the next clk edge):
  - cnt=0, res_vld=0, res_hit=0, res_idx=0, res_code=0.
  - All entries: en=0, val=0, code=0.
- Request, latency 1: when req_vld=1 at edge N:
  - sel = cnt value before edge N.
  - Winner = lowest index i with en[i]=1 and val[i]==sel. Comparison is full WIDTH, unsigned.
  - After edge N: res_vld=1, res_hit=1, res_idx=i, res_code=code[i].
  - No match: res_hit=0, res_idx=0, res_code holds its previous value (see optional feature).
- Counter, same edge as the request:
  - cnt <= cnt+1 mod 2^WIDTH; all-ones wraps to 0.
  - The match always uses the pre-increment value, never the incremented one.
- res_vld=0 on any cycle without a request. res_hit, res_idx and res_code hold their values.
- Counter load: load_vld=1 sets cnt <= load_val and has priority over the increment.
- load_vld and req_vld in the same cycle:
  - The match uses the old cnt.
  - cnt becomes load_val; no increment is applied.
- cfg_we:
  - Writes entry cfg_idx at the edge.
  - cfg_idx ≥ NCASE is ignored, with no side effects.
  - A request in the same cycle matches against the pre-write table; the new entry affects only later requests.
- Duplicate val across enabled entries is legal; the lowest index wins.
- Reset mid-operation: any in-flight result is dropped and res_vld is forced to 0 immediately (async).
- No backpressure: one request per cycle sustained, with a result every cycle.

Optional Feature:
- Macro: CASE_SEL_DEFAULT_EN.
- When defined:
  - Adds a register-write path: ports dflt_we (in, 1) and dflt_code (in, OUTW).
  - Adds a default-code register, reset value 0.
  - On a no-match request, res_code = default code (the value as of before the edge) and res_hit=0.
- When undefined: the ports are absent and a no-match request holds the previous res_code.

Test Plan:
- Reset, then req_vld for 1 cycle with no entries enabled -> res_vld=1, res_hit=0, res_code=0, cnt=1.
- Entry0={val=3,code=1,en}, entry1={val=0,code=2,en}; load cnt=3; req -> res_hit=1, res_idx=0, res_code=1, cnt=4 (match on 3, not 4).
- Load cnt=15 (WIDTH=4); two back-to-back reqs with entry1 val=0 -> first result no-match and code held at previous; cnt wraps to 0; second result res_idx=1, res_code=2, cnt=1.
- Entry0 and entry1 both val=5, enabled; req at cnt=5 -> res_idx=0 (priority).
- Same cycle: req at cnt=2, load_val=9, cfg_we writing entry0 val=2 -> match uses the old table and old cnt=2; cnt=9 afterward; next req at cnt=9 sees the new entry0.
- Assert rst_n low between a request edge and the next edge -> all outputs 0 immediately; CASE_SEL_DEFAULT_EN build: default=0xAA, no-match req -> res_code=0xAA, res_hit=0.

Source files
------------

// File: rtl/case_sel_counter.sv
// Selector counter with a programmable priority case table; each request matches the
// pre-increment count. Optional default-code register under CASE_SEL_DEFAULT_EN.
module case_sel_counter #(
  parameter int WIDTH = 4,
  parameter int NCASE = 2,
  parameter int OUTW  = 32,
  parameter int IDXW  = (NCASE > 1) ? $clog2(NCASE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [WIDTH-1:0] cfg_val,
  input  logic [OUTW-1:0]  cfg_code,
  input  logic             cfg_en,
  input  logic             req_vld,
`ifdef CASE_SEL_DEFAULT_EN
  input  logic             dflt_we,
  input  logic [OUTW-1:0]  dflt_code,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             res_vld,
  output logic             res_hit,
  output logic [IDXW-1:0]  res_idx,
  output logic [OUTW-1:0]  res_code
);

  logic             ent_en   [NCASE];
  logic [WIDTH-1:0] ent_val  [NCASE];
  logic [OUTW-1:0]  ent_code [NCASE];

  logic             hit_p0;
  logic [IDXW-1:0]  idx_p0;
  logic [OUTW-1:0]  code_p0;

`ifdef CASE_SEL_DEFAULT_EN
  logic [OUTW-1:0]  dflt_q;
`endif

  // Stage p0: priority match of the current (pre-increment) count against the table
  always_comb begin
    hit_p0  = 1'b0;
    idx_p0  = '0;
    code_p0 = '0;
    for (int i = NCASE - 1; i >= 0; i--) begin
      if (ent_en[i] && (ent_val[i] == cnt)) begin
        hit_p0  = 1'b1;
        idx_p0  = IDXW'(i);
        code_p0 = ent_code[i];
      end
    end
  end

  // Table writes; an out-of-range cfg_idx matches no entry and is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCASE; i++) begin
        ent_en[i]   <= 1'b0;
        ent_val[i]  <= '0;
        ent_code[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NCASE; i++) begin
        if (cfg_idx == IDXW'(i)) begin
          ent_en[i]   <= cfg_en;
          ent_val[i]  <= cfg_val;
          ent_code[i] <= cfg_code;
        end
      end
    end
  end

`ifdef CASE_SEL_DEFAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dflt_q <= '0;
    else if (dflt_we) dflt_q <= dflt_code;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (load_vld) cnt <= load_val;
    else if (req_vld)  cnt <= cnt + 1'b1;
  end

  // Stage p1: registered result; hit/idx/code hold between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld  <= 1'b0;
      res_hit  <= 1'b0;
      res_idx  <= '0;
      res_code <= '0;
    end else begin
      res_vld <= req_vld;
      if (req_vld) begin
        res_hit <= hit_p0;
        res_idx <= idx_p0;
        if (hit_p0)
          res_code <= code_p0;
`ifdef CASE_SEL_DEFAULT_EN
        else
          res_code <= dflt_q;
`endif
      end
    end
  end

endmodule
